// File: rtl/mac_l2_pkg.sv
// -----------------------------------------------------------------------------
// mac_l2_pkg
// Shared definitions for the layer-2 MAC sequencer slice:
//   - state_t       : sequencer FSM states (IDLE / RUN / DRAIN)
//   - DEF_IN_W      : default signed product width
//   - DEF_TREE_LAYERS: default growth bits of the five-input adder tree
//   - DEF_ACC_W     : default neuron accumulator width
//   - cnt_w()       : counter width for a modulus, never narrower than 1 bit
// -----------------------------------------------------------------------------
package mac_l2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_IN_W        = 59;
    localparam int DEF_TREE_LAYERS = 3;
    localparam int DEF_ACC_W       = 64;

    // Width of a counter that has to hold 0..n-1; a 1-bit floor keeps
    // degenerate moduli (1 or 2) from producing zero-width vectors.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_l2_accumulator.sv
// -----------------------------------------------------------------------------
// mac_l2_accumulator
// Tracks the one-cycle adder-tree latency, sign-extends each tree sum and
// accumulates the chunks of one neuron. On the last chunk the total is loaded
// into the result register, which holds until the consumer takes it.
//
// Optional feature: define MAC_L2_RELU_EN to clamp negative sums to zero as
// they are loaded into the result register (no extra latency).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        zero the accumulator (start of a layer pass)
//   accept       a product vector entered the tree this cycle
//   first, last  chunk position of the vector being accepted
//   idx          neuron index of the vector being accepted
//   tree_out     tree sum, valid one cycle after accept
//   out_ready    consumer takes the result
//   out_valid    result register holds an unconsumed result
//   out_data     signed neuron sum
//   out_idx      neuron index of out_data
// -----------------------------------------------------------------------------
module mac_l2_accumulator
    import mac_l2_pkg::*;
#(
    parameter int TREE_W = DEF_IN_W + DEF_TREE_LAYERS,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int IDX_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     accept,
    input  logic                     first,
    input  logic                     last,
    input  logic [IDX_W-1:0]         idx,
    input  logic signed [TREE_W-1:0] tree_out,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [IDX_W-1:0]         out_idx
);

    logic                    vld_p1;
    logic                    first_p1;
    logic                    last_p1;
    logic [IDX_W-1:0]        idx_p1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_p1;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [TREE_W-1:0] v);
        return ACC_W'(v);
    endfunction

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef MAC_L2_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Stage p1: tree result arrives; the first chunk restarts the sum.
    assign sum_p1 = first_p1 ? sext(tree_out) : (acc + sext(tree_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            vld_p1 <= accept;
            // The sequencer never accepts while a result is pending, so a
            // new load cannot collide with an unconsumed result.
            if (vld_p1 && last_p1) begin
                out_valid <= 1'b1;
                out_data  <= relu(sum_p1);
                out_idx   <= idx_p1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Datapath side of the pipeline; only meaningful alongside vld_p1.
    always_ff @(posedge clk) begin
        if (accept) begin
            first_p1 <= first;
            last_p1  <= last;
            idx_p1   <= idx;
        end
        if (clear) begin
            acc <= '0;
        end else if (vld_p1) begin
            acc <= sum_p1;
        end
    end

endmodule

// File: rtl/mac_l2_sequencer.sv
// -----------------------------------------------------------------------------
// mac_l2_sequencer
// Sequences the layer-2 five-input adder tree across multi-chunk neurons:
// accepts product vectors, forwards them to the tree, and emits one signed
// sum per neuron together with its index.
//
// Optional feature: MAC_L2_RELU_EN (see mac_l2_accumulator) clamps negative
// neuron sums to zero.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a layer pass (ignored while busy)
//   busy         layer pass in progress
//   done         pulses with the handshake of the last neuron result
//   in_valid/in_ready/in_data   product vectors, lane 0 in the LSBs
//   tree_in      tree input (in_data on accept, zero otherwise)
//   tree_out     tree sum, one cycle after the matching accept
//   out_valid/out_ready/out_data/out_idx   neuron results
// -----------------------------------------------------------------------------
module mac_l2_sequencer
    import mac_l2_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int FAN_IN      = 20,
    parameter int TREE_WIDTH  = 5,
    parameter int IN_W        = DEF_IN_W,
    parameter int TREE_LAYERS = DEF_TREE_LAYERS,
    parameter int ACC_W       = DEF_ACC_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [TREE_WIDTH*IN_W-1:0]       in_data,
    output logic [TREE_WIDTH*IN_W-1:0]       tree_in,
    input  logic [IN_W+TREE_LAYERS-1:0]      tree_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_W-1:0]                 out_data,
    output logic [cnt_w(NUM_NEURONS)-1:0]    out_idx
);

    localparam int CHUNKS = FAN_IN / TREE_WIDTH;
    localparam int CW     = cnt_w(CHUNKS);
    localparam int NW     = cnt_w(NUM_NEURONS);

    state_t         state;
    logic [CW-1:0]  chunk_cnt;
    logic [NW-1:0]  neuron_cnt;
    logic           last_inflight;
    logic           accept;
    logic           first_chunk;
    logic           last_chunk;
    logic           last_neuron;
    logic           clear;

    // Stalling while the final chunk is in the tree and while a result is
    // pending keeps the single result register from being overwritten.
    assign in_ready    = (state == RUN) && !out_valid && !last_inflight;
    assign accept      = in_valid && in_ready;
    assign first_chunk = (chunk_cnt == '0);
    assign last_chunk  = (chunk_cnt == CW'(CHUNKS - 1));
    assign last_neuron = (neuron_cnt == NW'(NUM_NEURONS - 1));
    assign tree_in     = accept ? in_data : '0;
    assign busy        = (state != IDLE);
    assign done        = (state == DRAIN) && out_valid && out_ready;
    assign clear       = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            chunk_cnt     <= '0;
            neuron_cnt    <= '0;
            last_inflight <= 1'b0;
        end else begin
            last_inflight <= accept && last_chunk;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        chunk_cnt  <= '0;
                        neuron_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_chunk) begin
                            chunk_cnt  <= '0;
                            neuron_cnt <= neuron_cnt + NW'(1);
                            if (last_neuron) begin
                                state <= DRAIN;
                            end
                        end else begin
                            chunk_cnt <= chunk_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mac_l2_accumulator #(
        .TREE_W (IN_W + TREE_LAYERS),
        .ACC_W  (ACC_W),
        .IDX_W  (NW)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .accept    (accept),
        .first     (first_chunk),
        .last      (last_chunk),
        .idx       (neuron_cnt),
        .tree_out  (tree_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

endmodule

// File: tb/tb_mac_l2_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_l2_sequencer
// Directed bench for mac_l2_sequencer with TREE_WIDTH=5, FAN_IN=10 (two chunks
// per neuron) and NUM_NEURONS=2. A registered five-lane sum stands in for the
// adder tree. Expected sums are hand-computed; MAC_L2_RELU_EN selects the
// clamped expectation for negative sums.
// -----------------------------------------------------------------------------
module tb_mac_l2_sequencer;

    localparam int NN = 2;
    localparam int FI = 10;
    localparam int TW = 5;
    localparam int IW = 59;
    localparam int TL = 3;
    localparam int AW = 64;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    start     = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    out_ready = 1'b0;
    logic [TW*IW-1:0]        in_data   = '0;
    logic signed [IW+TL-1:0] tree_out  = '0;
    logic                    busy;
    logic                    done;
    logic                    in_ready;
    logic [TW*IW-1:0]        tree_in;
    logic                    out_valid;
    logic [AW-1:0]           out_data;
    logic [0:0]              out_idx;

    int            n_tests  = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    logic [AW-1:0] res_d[$];
    int            res_i[$];

    always #5 clk = ~clk;

    mac_l2_sequencer #(
        .NUM_NEURONS (NN),
        .FAN_IN      (FI),
        .TREE_WIDTH  (TW),
        .IN_W        (IW),
        .TREE_LAYERS (TL),
        .ACC_W       (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tree_in   (tree_in),
        .tree_out  (tree_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    // Adder tree model: registered sum of the five signed lanes.
    always @(posedge clk) begin
        logic signed [IW+TL-1:0] s;
        s = '0;
        for (int l = 0; l < TW; l++) s = s + $signed(tree_in[l*IW +: IW]);
        tree_out <= s;
    end

    // Inputs change just after the rising edge, so the falling-edge values
    // are the ones the next rising edge will see.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            res_d.push_back(out_data);
            res_i.push_back(int'(out_idx));
        end
        if (done) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint exp_sum(input longint v);
`ifdef MAC_L2_RELU_EN
        return (v < 0) ? 64'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one vector with every lane equal to v and hold it until it
    // is accepted; returns at edge+1 of the cycle after the accept.
    task automatic send_vec(input longint v);
        bit ok;
        int k;
        ok = 1'b0;
        k  = 0;
        for (int l = 0; l < TW; l++) in_data[l*IW +: IW] = v[IW-1:0];
        in_valid = 1'b1;
        while (!ok && k < 30) begin
            if (in_ready) ok = 1'b1;
            tick();
            k++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input string tag, input int base_done);
        int k;
        k = 0;
        while (done_cnt == base_done && k < 60) begin
            tick();
            k++;
        end
        chk({tag, "_done_cnt"}, 64'(done_cnt - base_done), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_results(input string tag, input int base, input longint e0, input longint e1);
        chk({tag, "_nres"}, 64'(res_d.size() - base), 64'd2);
        if (res_d.size() >= base + 2) begin
            chk({tag, "_data0"}, res_d[base],       64'(e0));
            chk({tag, "_idx0"},  64'(res_i[base]),  64'd0);
            chk({tag, "_data1"}, res_d[base+1],     64'(e1));
            chk({tag, "_idx1"},  64'(res_i[base+1]), 64'd1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
        chk({tag, "_tree_in"},   64'(tree_in[AW-1:0] | tree_in[TW*IW-1 -: AW]), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"},  out_data,       64'd0);
        chk({tag, "_out_idx"},   64'(out_idx),   64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_done"},      64'(done),      64'd0);
    endtask

    initial begin
        int     b;
        int     bd;
        int     k;
        longint mn;
        mn = -(64'sd1 <<< (IW - 1));

        // Reset state, with a vector offered that must not reach the tree.
        in_valid = 1'b1;
        in_data  = '1;
        tick(); tick();
        chk_reset_outputs("reset");
        in_valid = 1'b0;
        in_data  = '0;
        rst_n    = 1'b1;
        tick();

        // in_valid while IDLE is never accepted.
        in_valid = 1'b1;
        for (int l = 0; l < TW; l++) in_data[l*IW +: IW] = 59'd9;
        tick(); tick(); tick();
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_no_result", 64'(res_d.size()), 64'd0);
        in_valid = 1'b0;
        in_data  = '0;

        // Basic pass: all lanes 1, out_ready high, start pulsed mid-pass.
        b  = res_d.size();
        bd = done_cnt;
        out_ready = 1'b1;
        pulse_start();
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_in_ready", 64'(in_ready), 64'd1);
        send_vec(1);
        send_vec(1);
        chk("lat0_t1_out_valid", 64'(out_valid), 64'd0);
        chk("lat0_t1_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("lat0_t2_out_valid", 64'(out_valid), 64'd1);
        chk("lat0_t2_in_ready", 64'(in_ready), 64'd0);
        pulse_start();
        chk("midstart_busy", 64'(busy), 64'd1);
        send_vec(1);
        send_vec(1);
        chk("lat1_t1_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lat1_t2_out_valid", 64'(out_valid), 64'd1);
        wait_done("basic", bd);
        chk_results("basic", b, 10, 10);

        // Signed sums: (-3)*5 + 1*5 = -10, then 2*5 + 1*5 = 15.
        b  = res_d.size();
        bd = done_cnt;
        pulse_start();
        send_vec(-3);
        send_vec(1);
        send_vec(2);
        send_vec(1);
        wait_done("signed", bd);
        chk_results("signed", b, exp_sum(-10), 15);

        // Backpressure: result 0 (70) held for five cycles.
        b  = res_d.size();
        bd = done_cnt;
        out_ready = 1'b0;
        pulse_start();
        send_vec(7);
        send_vec(7);
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_data", out_data, 64'd70);
            chk("bp_out_idx", 64'(out_idx), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        send_vec(2);
        send_vec(-1);
        wait_done("bp", bd);
        chk_results("bp", b, 70, 5);

        // Extreme values: every lane at -2^58 -> -10*2^58, no wrap.
        b  = res_d.size();
        bd = done_cnt;
        pulse_start();
        send_vec(mn);
        send_vec(mn);
        send_vec(mn);
        send_vec(mn);
        wait_done("extreme", bd);
        chk_results("extreme", b, exp_sum(mn * 10), exp_sum(mn * 10));

        // Reset mid-pass after chunk 0 of neuron 1, then a clean pass.
        pulse_start();
        send_vec(3);
        send_vec(3);
        send_vec(4);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        b  = res_d.size();
        bd = done_cnt;
        pulse_start();
        send_vec(3);
        send_vec(3);
        send_vec(4);
        send_vec(1);
        wait_done("postrst", bd);
        chk_results("postrst", b, 30, 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
